// File: rtl/softmax_norm_ctrl.sv
// Softmax row normaliser: requests 1/sum from a start/busy/done reciprocal unit, then streams
// exp*(1/sum) with saturation. Optional WAIT watchdog enabled by SOFTMAX_NORM_TIMEOUT_EN.
module softmax_norm_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned Q           = 26,
  parameter int unsigned MAX_LEN     = 1024,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic [WIDTH-1:0] sum_q,
  input  logic [CNT_W-1:0] row_len,
  output logic             recip_start,
  output logic [WIDTH-1:0] recip_a_q,
  input  logic             recip_busy,
  input  logic             recip_done,
  input  logic [WIDTH-1:0] recip_y_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_last,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StNorm} state_e;

  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [2*WIDTH-1:0] ProdMax = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] ProdMin = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_e                    state_q;
  logic [CNT_W-1:0]          len_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [WIDTH-1:0]          recip_q;
  logic                      in_done;
  logic                      in_xfer;
  logic                      out_xfer;
  logic                      sum_nonpos;
  logic                      tmo_hit;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic [WIDTH-1:0]          norm_val;

  assign sum_ready  = (state_q == StIdle);
  assign in_done    = (cnt_q == len_q);
  // Input is only taken once recip_q is valid and the output register can accept a new value.
  assign in_ready   = (state_q == StNorm) && !in_done && (!out_valid || out_ready);
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign sum_nonpos = sum_q[WIDTH-1] || (sum_q == '0);

  always_comb begin
    prod     = $signed({{WIDTH{in_q[WIDTH-1]}}, in_q}) *
               $signed({{WIDTH{recip_q[WIDTH-1]}}, recip_q});
    prod_sh  = prod >>> Q;
    norm_val = prod_sh[WIDTH-1:0];
    if (prod_sh > ProdMax) begin
      norm_val = SatMax;
    end else if (prod_sh < ProdMin) begin
      norm_val = SatMin;
    end
  end

`ifdef SOFTMAX_NORM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_q;

  // Counts cycles spent in WAIT; fires on the last allowed cycle without a done pulse.
  assign tmo_hit = (state_q == StWait) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q != StWait) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      recip_q     <= '0;
      recip_a_q   <= '0;
      recip_start <= 1'b0;
      out_valid   <= 1'b0;
      out_q       <= '0;
      out_last    <= 1'b0;
      err         <= 1'b0;
    end else begin
      recip_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A zero-length row completes the handshake but starts nothing.
          if (sum_valid && (row_len != '0)) begin
            len_q     <= row_len;
            cnt_q     <= '0;
            recip_a_q <= sum_q;
            err       <= 1'b0;
            if (sum_nonpos) begin
              recip_q <= SatMax;
              err     <= 1'b1;
              state_q <= StNorm;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StReq: begin
          if (!recip_busy) begin
            recip_start <= 1'b1;
            state_q     <= StWait;
          end
        end
        StWait: begin
          if (recip_done) begin
            recip_q <= recip_y_q;
            state_q <= StNorm;
          end else if (tmo_hit) begin
            recip_q <= SatMax;
            err     <= 1'b1;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (in_xfer) begin
            out_valid <= 1'b1;
            out_q     <= norm_val;
            out_last  <= ((cnt_q + 1'b1) == len_q);
            cnt_q     <= cnt_q + 1'b1;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/softmax_norm_ctrl.md
Name: softmax_norm_ctrl

Overview:
Initiator side of the softmax reciprocal handshake. Accepts the exp-sum of one softmax row and drives a start/busy/done reciprocal unit to get 1/sum. It then streams that row's exp values through a registered multiply, emitting normalized probabilities exp*(1/sum) in Q format. It sits between the exp/accumulate stage and the softmax output buffer.

Parameters:
WIDTH, 32, data width of all Q-format values
Q, 26, fractional bits (Q5.26)
MAX_LEN, 1024, maximum row length; CNT_W = $clog2(MAX_LEN+1)
TIMEOUT_CYC, 64, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sum_valid  in  1  row sum and length are valid
sum_ready  out  1  controller accepts a new row (high only in IDLE)
sum_q  in  WIDTH  signed exp-sum, Q format
row_len  in  CNT_W  number of exp elements in the row
recip_start  out  1  one-cycle start pulse to the reciprocal unit
recip_a_q  out  WIDTH  operand to the reciprocal unit (latched sum)
recip_busy  in  1  reciprocal unit busy
recip_done  in  1  one-cycle result-valid pulse
recip_y_q  in  WIDTH  reciprocal result, Q format
in_valid  in  1  exp element valid
in_ready  out  1  exp element accepted
in_q  in  WIDTH  signed exp element, Q format
out_valid  out  1  normalized element valid
out_ready  in  1  downstream accepts
out_q  out  WIDTH  normalized element, Q format
out_last  out  1  marks the final element of the row
err  out  1  sticky: non-positive sum or watchdog expiry; cleared on next row accept

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, except sum_ready=1 (IDLE). FSM returns to IDLE. Counters, latched sum and latched recip are cleared.
- Reset mid-operation: abandons the row. recip_start is low from reset assertion onward. A recip_done arriving later is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, NORM.
- IDLE:
  - On sum_valid && row_len != 0: latch sum_q and row_len; clear err.
  - If sum_q <= 0: set recip_reg = 0x7FFF_FFFF (max positive), set err, go to NORM with no request.
  - Otherwise go to REQ.
  - row_len == 0 is accepted (handshake completes), produces no outputs and no request, and the FSM stays in IDLE.
- REQ:
  - If recip_busy=0, pulse recip_start for exactly one cycle and go to WAIT.
  - Otherwise hold in REQ with recip_start low.
  - recip_a_q is held at the latched sum from REQ until the next row is accepted.
- WAIT:
  - On recip_done, latch recip_y_q into recip_reg and go to NORM next cycle.
  - recip_done in any other state is ignored.
- NORM:
  - in_ready = !out_valid || out_ready.
  - On an in_valid && in_ready transfer: prod = in_q * recip_reg (signed, 2*WIDTH), shifted arithmetically right by Q.
  - Saturate to signed WIDTH: above 0x7FFF_FFFF gives 0x7FFF_FFFF; below 0x8000_0000 gives 0x8000_0000.
  - Result is registered into out_q. Latency from input transfer to out_valid is 1 cycle.
  - out_valid, out_q and out_last hold stable while out_valid && !out_ready.
  - Element counter increments per input transfer. out_last=1 on the element where count == row_len.
  - After the last input transfer, in_ready=0.
  - When the last output is accepted (out_valid && out_ready && out_last), go to IDLE in the same cycle edge. sum_ready rises the next cycle.
- Simultaneous events: an output accept and a new input transfer in the same cycle are both honoured (full throughput, 1 element/cycle).
- in_ready is 0 outside NORM. Input is never accepted before recip_reg is valid.

Optional Feature:
- Macro SOFTMAX_NORM_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If TIMEOUT_CYC cycles pass with no recip_done, set recip_reg = 0x7FFF_FFFF, set err, and go to NORM. A late recip_done is ignored.
- Undefined: no counter logic; WAIT holds indefinitely until recip_done.

Test Plan:
- Basic row: sum_q=0x1000_0000 (4.0), row_len=2; model unit returns done after 10 cycles with 0x0100_0000 (0.25); inputs 0x0800_0000 and 0x0400_0000 -> one recip_start pulse with recip_a_q=0x1000_0000; out_q=0x0200_0000 then 0x0100_0000; out_last on the second output; err=0.
- Busy hold: recip_busy=1 for 5 cycles after row accept -> recip_start stays low, pulses exactly once in the cycle after busy falls.
- Backpressure: row_len=4, out_ready toggled 1,0,0,1... -> out_q stable while stalled; no element lost or duplicated; in_ready low while out_valid && !out_ready.
- Non-positive sum: sum_q=0xFFFF_0000, row_len=1, in_q=0x0400_0000 -> no recip_start, err=1, out_q=0x7FFF_FFFF (saturated), out_last=1.
- Saturation: recip=0x4000_0000 (16.0), in_q=0x7000_0000 -> out_q=0x7FFF_FFFF; in_q=0x9000_0000 -> out_q=0x8000_0000.
- Reset mid-WAIT, then rst_n released and the model later pulses recip_done -> controller stays in IDLE with sum_ready=1, out_valid=0. With SOFTMAX_NORM_TIMEOUT_EN defined and no done for 64 cycles -> err=1 and the row completes with out_q saturated.
